reg_scoreboard: RTL and testbench

- Tracks outstanding register writes for the in-order 5-stage RISC-V pipeline.
- Sits beside the decode stage and replaces the ad-hoc rd comparisons against the AGEX, MEM and WB stages.
- Decode issues an instruction only when the scoreboard reports no RAW hazard. WB retires entries; an AGEX branch redirect suppresses issue.
- Provides the stall signal that DE forwards to FE.

---
 rtl/reg_scoreboard_pkg.sv | 8 +
 rtl/reg_scoreboard_sb_entry.sv | 39 +++
 rtl/reg_scoreboard.sv | 108 ++++++++++
 tb/tb_reg_scoreboard.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
// rtl/reg_scoreboard_pkg.sv - shared scoreboard sizing constants
// Register index width mirrors the pipeline's REGNOBITS define.
package reg_scoreboard_pkg;
  localparam int SB_REGNOBITS = 5;
  localparam int SB_NREGS     = 32;
  localparam int SB_CNTBITS   = 2;
  localparam int SB_CNTMAX    = (1 << SB_CNTBITS) - 1;
endpackage

// File: rtl/reg_scoreboard_sb_entry.sv
// rtl/reg_scoreboard_sb_entry.sv - per-register pending-writer counter
// Saturating up/down counter; nz_o reflects the value after the coming edge.
module sb_entry
  import reg_scoreboard_pkg::*;
#(
  parameter int CNTBITS = SB_CNTBITS
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               inc_i,
  input  logic               dec_i,
  output logic [CNTBITS-1:0] cnt_o,
  output logic               nz_o,
  output logic               underflow_o
);

  logic [CNTBITS-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d       = cnt_q;
    underflow_o = 1'b0;
    if (inc_i && !dec_i) begin
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      // Retiring a register with nothing pending is a protocol error, not a wrap.
      if (cnt_q == '0) underflow_o = 1'b1;
      else             cnt_d       = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign nz_o  = (cnt_d != '0);

endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - RAW hazard scoreboard beside the decode stage
// Optional SCOREBOARD_PERF_EN adds stall_cycles_o / issued_count_o counters.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NREGS     = SB_NREGS,
  parameter int REGNOBITS = SB_REGNOBITS,
  parameter int CNTBITS   = SB_CNTBITS
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 issue_valid_i,
  input  logic                 issue_wr_reg_i,
  input  logic [REGNOBITS-1:0] issue_rd_i,
  input  logic [REGNOBITS-1:0] rs1_i,
  input  logic                 rs1_read_i,
  input  logic [REGNOBITS-1:0] rs2_i,
  input  logic                 rs2_read_i,
  input  logic                 flush_i,
  input  logic                 wb_valid_i,
  input  logic [REGNOBITS-1:0] wb_rd_i,
  output logic                 stall_o,
  output logic                 issue_ack_o,
  output logic                 busy_o,
  output logic                 err_underflow_o
`ifdef SCOREBOARD_PERF_EN
  ,
  output logic [31:0]          stall_cycles_o,
  output logic [31:0]          issued_count_o
`endif
);

  localparam logic [CNTBITS-1:0] CNT_MAX = '1;
  localparam logic [CNTBITS-1:0] CNT_ONE = CNTBITS'(1);

  logic [CNTBITS-1:0] cnt [NREGS];
  logic [NREGS-1:1]   inc, dec, nz, underflow;

  logic [CNTBITS-1:0] cnt_rs1, cnt_rs2, cnt_rd;
  logic               haz_rs1, haz_rs2, full;
  logic               busy_q, err_underflow_q;

  assign cnt[0] = '0;

  for (genvar r = 1; r < NREGS; r++) begin : g_entry
    assign inc[r] = issue_ack_o && issue_wr_reg_i && (issue_rd_i == REGNOBITS'(r));
    assign dec[r] = wb_valid_i && (wb_rd_i == REGNOBITS'(r));

    sb_entry #(.CNTBITS(CNTBITS)) u_entry (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .inc_i       (inc[r]),
      .dec_i       (dec[r]),
      .cnt_o       (cnt[r]),
      .nz_o        (nz[r]),
      .underflow_o (underflow[r])
    );
  end

  // Indices are only looked up when their valid bit is set so no X leaks out.
  always_comb begin
    cnt_rs1 = rs1_read_i ? cnt[rs1_i] : '0;
    cnt_rs2 = rs2_read_i ? cnt[rs2_i] : '0;
    cnt_rd  = (issue_valid_i && issue_wr_reg_i) ? cnt[issue_rd_i] : '0;

    // A last-writer retiring this cycle is already in the register file (negedge write).
    haz_rs1 = rs1_read_i && (rs1_i != '0) && (cnt_rs1 != '0) &&
              !(wb_valid_i && (wb_rd_i == rs1_i) && (cnt_rs1 == CNT_ONE));
    haz_rs2 = rs2_read_i && (rs2_i != '0) && (cnt_rs2 != '0) &&
              !(wb_valid_i && (wb_rd_i == rs2_i) && (cnt_rs2 == CNT_ONE));
    full    = issue_wr_reg_i && (issue_rd_i != '0) && (cnt_rd == CNT_MAX) &&
              !(wb_valid_i && (wb_rd_i == issue_rd_i));

    stall_o     = issue_valid_i && !flush_i && (haz_rs1 || haz_rs2 || full);
    issue_ack_o = issue_valid_i && !flush_i && !stall_o;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_q          <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      busy_q          <= |nz;
      err_underflow_q <= err_underflow_q || (|underflow);
    end
  end

  assign busy_o          = busy_q;
  assign err_underflow_o = err_underflow_q;

`ifdef SCOREBOARD_PERF_EN
  logic [31:0] stall_cycles_q, issued_count_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_cycles_q <= '0;
      issued_count_q <= '0;
    end else begin
      if (stall_o)     stall_cycles_q <= stall_cycles_q + 32'd1;
      if (issue_ack_o) issued_count_q <= issued_count_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign issued_count_o = issued_count_q;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - directed self-checking bench for reg_scoreboard
// Covers SCOREBOARD_PERF_EN counters when that macro is defined.
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid, issue_wr_reg, rs1_read, rs2_read, flush, wb_valid;
  logic [4:0] issue_rd, rs1, rs2, wb_rd;
  logic       stall, issue_ack, busy, err_underflow;
`ifdef SCOREBOARD_PERF_EN
  logic [31:0] stall_cycles, issued_count;
`endif

  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .issue_valid_i   (issue_valid),
    .issue_wr_reg_i  (issue_wr_reg),
    .issue_rd_i      (issue_rd),
    .rs1_i           (rs1),
    .rs1_read_i      (rs1_read),
    .rs2_i           (rs2),
    .rs2_read_i      (rs2_read),
    .flush_i         (flush),
    .wb_valid_i      (wb_valid),
    .wb_rd_i         (wb_rd),
    .stall_o         (stall),
    .issue_ack_o     (issue_ack),
    .busy_o          (busy),
    .err_underflow_o (err_underflow)
`ifdef SCOREBOARD_PERF_EN
    ,
    .stall_cycles_o  (stall_cycles),
    .issued_count_o  (issued_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 0; issue_wr_reg = 0; issue_rd = 0;
    rs1 = 0; rs1_read = 0; rs2 = 0; rs2_read = 0;
    flush = 0; wb_valid = 0; wb_rd = 0;
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [4:0] rd,
                       input logic r1, input logic [4:0] s1);
    idle();
    issue_valid = 1; issue_wr_reg = wr; issue_rd = rd;
    rs1_read = r1; rs1 = s1;
  endtask

  task automatic retire(input logic [4:0] rd);
    wb_valid = 1; wb_rd = rd;
  endtask

  initial begin
    idle();
    reset = 1;
    cyc(); cyc();
    reset = 0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_err", err_underflow, 0);
    chk("reset_stall", stall, 0);
    chk("reset_ack", issue_ack, 0);

    // Producer to x5, then dependent read stalls until the bypass retire.
    issue(1, 5, 0, 0); #1;
    chk("issue5_ack", issue_ack, 1);
    chk("issue5_stall", stall, 0);
    cyc();
    chk("issue5_busy", busy, 1);
    issue(0, 0, 1, 5); #1;
    chk("raw5_stall", stall, 1);
    chk("raw5_ack", issue_ack, 0);
    retire(5); #1;
    chk("raw5_bypass_stall", stall, 0);
    chk("raw5_bypass_ack", issue_ack, 1);
    cyc();
    chk("raw5_cleared_busy", busy, 0);
    issue(0, 0, 1, 5); #1;
    chk("raw5_after_stall", stall, 0);

    // x0 is never tracked.
    issue(1, 0, 0, 0); #1;
    chk("x0_wr_ack", issue_ack, 1);
    cyc();
    chk("x0_busy", busy, 0);
    issue(0, 0, 1, 0); #1;
    chk("x0_rd_stall", stall, 0);
    cyc();
    chk("x0_busy2", busy, 0);

    // Three writers to x7 fill the counter; a fourth only goes with a same-cycle retire.
    for (int i = 0; i < 3; i++) begin
      issue(1, 7, 0, 0); #1;
      chk("fill7_ack", issue_ack, 1);
      cyc();
    end
    issue(1, 7, 0, 0); #1;
    chk("full7_stall", stall, 1);
    chk("full7_ack", issue_ack, 0);
    retire(7); #1;
    chk("full7_wb_stall", stall, 0);
    chk("full7_wb_ack", issue_ack, 1);
    cyc();
    issue(1, 7, 0, 0); #1;
    chk("full7_still_full", stall, 1);
    idle(); retire(7); cyc();
    retire(7); cyc();
    chk("drain7_busy_mid", busy, 1);
    retire(7); cyc();
    chk("drain7_busy_done", busy, 0);
    chk("drain7_no_underflow", err_underflow, 0);

    // Flush suppresses stall and issue; retire during flush still counts.
    issue(1, 9, 0, 0); cyc();
    idle();
    issue_valid = 1; issue_wr_reg = 1; issue_rd = 3; rs2_read = 1; rs2 = 9; #1;
    chk("haz9_stall", stall, 1);
    flush = 1; #1;
    chk("flush_stall", stall, 0);
    chk("flush_ack", issue_ack, 0);
    retire(9); cyc();
    idle(); #1;
    chk("flush_busy", busy, 0);
    issue_valid = 1; rs2_read = 1; rs2 = 9; issue_wr_reg = 1; issue_rd = 3;
    rs1_read = 1; rs1 = 3; #1;
    chk("flush_no_haz", stall, 0);
    chk("flush_no_haz_ack", issue_ack, 1);
    cyc();
    idle(); retire(3); cyc();
    idle(); #1;
    chk("x3_retired_busy", busy, 0);

    // Underflow is sticky until reset.
    retire(12); #1;
    chk("uf_before", err_underflow, 0);
    cyc();
    idle(); #1;
    chk("uf_set", err_underflow, 1);
    cyc();
    chk("uf_sticky", err_underflow, 1);
    issue(1, 4, 0, 0);
    reset = 1; cyc();
    reset = 0; idle(); #1;
    chk("uf_reset", err_underflow, 0);
    chk("reset_overrides_issue", busy, 0);

`ifdef SCOREBOARD_PERF_EN
    issue(1, 6, 0, 0); cyc();
    for (int i = 0; i < 4; i++) begin
      issue(0, 0, 1, 6); cyc();
    end
    issue(0, 0, 1, 6); retire(6); cyc();
    for (int i = 0; i < 8; i++) begin
      issue(0, 0, 0, 0); cyc();
    end
    idle(); cyc();
    chk("perf_stalls", stall_cycles, 4);
    chk("perf_issued", issued_count, 10);
    reset = 1; cyc();
    reset = 0;
    chk("perf_stalls_rst", stall_cycles, 0);
    chk("perf_issued_rst", issued_count, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
